alu_cu_seq: RTL and testbench

//  Parametrised, handshaked successor to the combinational ALU control decoder, sitting between ID/EX and the ALU.

---
 rtl/alu_cu_seq_if.sv | 26 ++
 rtl/alu_cu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_cu_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_cu_seq_if.sv
// Handshake bundle between the ID/EX stage, the ALU control decoder and its consumer.
// The master side is the pipeline (producer and consumer); the slave side is the decoder.
interface alu_cu_seq_if #(
  parameter int unsigned FUN_W = 6,
  parameter int unsigned OP_W  = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [FUN_W-1:0] Fun6;
  logic [1:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  Operation;
  logic             Busy;
  logic             Illegal;

  modport master (
    output in_valid, Fun6, ALUOp, out_ready,
    input  in_ready, out_valid, Operation, Busy, Illegal
  );

  modport slave (
    input  in_valid, Fun6, ALUOp, out_ready,
    output in_ready, out_valid, Operation, Busy, Illegal
  );
endinterface

// File: rtl/alu_cu_seq.sv
// Registered, handshaked ALU control decoder: decodes {ALUOp, Fun6} into an Operation code.
// MUL/DIV/REM hold the decoder busy for a parameterised latency before the result is presented.
module alu_cu_seq #(
  parameter int unsigned FUN_W   = 6,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  alu_cu_seq_if.slave bus
);
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [OP_W-1:0]  op_q, op_nx;
  logic             vld_q, vld_nx;
  logic             busy_q, busy_nx;
  logic             ill_q, ill_nx;

  logic             in_rdy;
  logic             accept;
  logic             transfer;

  logic [OP_W-1:0]  dec_op;
  logic             dec_ill;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_cnt;

  always_comb begin
    dec_op    = OP_W'(4'b1111);
    dec_ill   = 1'b0;
    dec_multi = 1'b0;
    dec_cnt   = '0;
    case (bus.ALUOp)
      2'b00: dec_op = OP_W'(4'b0010);
      2'b01: dec_op = OP_W'(4'b0110);
      2'b10: begin
        case (bus.Fun6)
          FUN_W'(6'b000000): dec_op = OP_W'(4'b0010);
          FUN_W'(6'b000010): dec_op = OP_W'(4'b0110);
          FUN_W'(6'b000100): dec_op = OP_W'(4'b0000);
          FUN_W'(6'b000101): dec_op = OP_W'(4'b0001);
          FUN_W'(6'b001010): dec_op = OP_W'(4'b0111);
          FUN_W'(6'b000111): dec_op = OP_W'(4'b1100);
          default:           dec_ill = 1'b1;
        endcase
      end
      default: begin
        // A latency of 1 behaves like a single-cycle op and skips BUSY entirely.
        case (bus.Fun6)
          FUN_W'(6'b011000): begin
            dec_op    = OP_W'(4'b1000);
            dec_multi = (MUL_LAT > 1);
            dec_cnt   = CNT_W'(MUL_LAT - 1);
          end
          FUN_W'(6'b011010): begin
            dec_op    = OP_W'(4'b1001);
            dec_multi = (DIV_LAT > 1);
            dec_cnt   = CNT_W'(DIV_LAT - 1);
          end
          FUN_W'(6'b011011): begin
            dec_op    = OP_W'(4'b1010);
            dec_multi = (DIV_LAT > 1);
            dec_cnt   = CNT_W'(DIV_LAT - 1);
          end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign in_rdy   = !rst && !flush && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign accept   = bus.in_valid && in_rdy;
  assign transfer = vld_q && bus.out_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    vld_nx   = vld_q;
    busy_nx  = busy_q;
    ill_nx   = ill_q;
    case (state)
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = HOLD;
          cnt_nx   = '0;
          vld_nx   = 1'b1;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        if (accept) begin
          op_nx  = dec_op;
          ill_nx = dec_ill;
          if (dec_multi) begin
            state_nx = BUSY;
            cnt_nx   = dec_cnt;
            vld_nx   = 1'b0;
            busy_nx  = 1'b1;
          end else begin
            state_nx = HOLD;
            cnt_nx   = '0;
            vld_nx   = 1'b1;
            busy_nx  = 1'b0;
          end
        end else if ((state == HOLD) && transfer) begin
          state_nx = IDLE;
          vld_nx   = 1'b0;
        end
      end
    endcase
    // Flush abandons any in-flight count; the last Operation/Illegal are left as they were.
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      vld_nx   = 1'b0;
      busy_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op_q   <= op_nx;
      vld_q  <= vld_nx;
      busy_q <= busy_nx;
      ill_q  <= ill_nx;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.Operation = op_q;
  assign bus.Busy      = busy_q;
  assign bus.Illegal   = ill_q;
endmodule

// File: tb/tb_alu_cu_seq.sv
// Bench for alu_cu_seq: directed scenarios followed by random traffic, all checked
// against a transaction-level model that tracks each accepted op and its due cycle.
module tb_alu_cu_seq;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  alu_cu_seq_if #(.FUN_W(6), .OP_W(4)) bus ();

  alu_cu_seq #(
    .FUN_W(6), .OP_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  // Model: at most one op outstanding; it becomes visible at cycle m_due.
  bit          m_pend  = 1'b0;
  int unsigned m_due   = 0;
  logic [3:0]  m_op    = 4'h0;
  logic        m_ill   = 1'b0;
  bit          m_known = 1'b0;

  logic [5:0] codes [9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h0A, 6'h07, 6'h18, 6'h1A, 6'h1B};
  logic [1:0] sw_a  [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0] sw_f  [7] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h0A};
  logic [3:0] sw_op [7] = '{4'h2, 4'h6, 4'h2, 4'h6, 4'h0, 4'h1, 4'h7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [1:0] a, input logic [5:0] f,
                                  output logic [3:0] op, output logic ill,
                                  output int unsigned lat);
    op = 4'hF; ill = 1'b0; lat = 1;
    if (a == 2'b00) op = 4'h2;
    else if (a == 2'b01) op = 4'h6;
    else if (a == 2'b10) begin
      if      (f == 6'h00) op = 4'h2;
      else if (f == 6'h02) op = 4'h6;
      else if (f == 6'h04) op = 4'h0;
      else if (f == 6'h05) op = 4'h1;
      else if (f == 6'h0A) op = 4'h7;
      else if (f == 6'h07) op = 4'hC;
      else ill = 1'b1;
    end else begin
      if      (f == 6'h18) begin op = 4'h8; lat = MUL_LAT; end
      else if (f == 6'h1A) begin op = 4'h9; lat = DIV_LAT; end
      else if (f == 6'h1B) begin op = 4'hA; lat = DIV_LAT; end
      else ill = 1'b1;
    end
  endfunction

  // Check the current cycle against the model, then advance one clock.
  task automatic tick();
    logic ev, eb, er, acc, dill;
    logic [3:0] dop;
    int unsigned dlat;
    #1;
    ev = m_pend && (cyc >= m_due);
    eb = m_pend && (cyc < m_due);
    er = !rst && !flush && (!m_pend || (ev && bus.out_ready));
    chk("out_valid", bus.out_valid, ev);
    chk("busy", bus.Busy, eb);
    chk("in_ready", bus.in_ready, er);
    if (m_known) begin
      chk("operation", bus.Operation, m_op);
      chk("illegal", bus.Illegal, m_ill);
    end
    acc = bus.in_valid && er;
    if (rst) begin
      m_pend = 1'b0; m_op = 4'h0; m_ill = 1'b0; m_known = 1'b1;
    end else if (flush) begin
      m_pend = 1'b0; m_known = 1'b0;
    end else if (acc) begin
      ref_dec(bus.ALUOp, bus.Fun6, dop, dill, dlat);
      m_pend = 1'b1; m_due = cyc + dlat; m_op = dop; m_ill = dill; m_known = 1'b1;
    end else if (ev && bus.out_ready) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.Fun6 = 6'h00; bus.out_ready = 1'b1;

    // Reset held for two cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.Busy, 1'b0);
    chk("rst_op", bus.Operation, 4'h0);
    chk("rst_illegal", bus.Illegal, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    m_pend = 1'b0; m_op = 4'h0; m_ill = 1'b0; m_known = 1'b1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Single-cycle sweep, one op per cycle.
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.ALUOp = sw_a[i]; bus.Fun6 = sw_f[i];
      tick();
      chk("sweep_op", bus.Operation, sw_op[i]);
      chk("sweep_valid", bus.out_valid, 1'b1);
    end

    // MUL latency.
    bus.ALUOp = 2'b11; bus.Fun6 = 6'h18;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      chk("mul_busy", bus.Busy, 1'b1);
      chk("mul_in_ready", bus.in_ready, 1'b0);
      chk("mul_op_hold", bus.Operation, 4'h8);
      tick();
    end
    chk("mul_valid", bus.out_valid, 1'b1);
    chk("mul_op", bus.Operation, 4'h8);
    tick();

    // Back-pressure on a SUB result.
    bus.in_valid = 1'b1; bus.ALUOp = 2'b01;
    tick();
    bus.out_ready = 1'b0; bus.ALUOp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_op", bus.Operation, 4'h6);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1'b1);
    tick();
    chk("bp_next_op", bus.Operation, 4'h2);
    bus.in_valid = 1'b0;
    tick();

    // Illegal function field.
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.Fun6 = 6'h3F;
    tick();
    chk("illegal_op", bus.Operation, 4'hF);
    chk("illegal_flag", bus.Illegal, 1'b1);
    bus.in_valid = 1'b0;
    tick();

    // Flush in the middle of a DIV.
    bus.in_valid = 1'b1; bus.ALUOp = 2'b11; bus.Fun6 = 6'h1A;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("div_busy", bus.Busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", bus.Busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("flush_no_valid", bus.out_valid, 1'b0);
    end

    // Reset in the middle of a DIV.
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_op", bus.Operation, 4'h0);
    chk("mid_rst_busy", bus.Busy, 1'b0);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 8; i++) tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.ALUOp     = 2'($urandom_range(0, 3));
      bus.Fun6      = ($urandom_range(0, 4) == 0) ? 6'($urandom) : codes[$urandom_range(0, 8)];
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
